register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Architectural register file directly downstream of the writeback stage; consumes its `write`, `wr1`/`wr2`, `wa1`/`wa2` outputs unchanged.
- 32 x 32-bit storage with two write ports, two registered read ports and same-edge write-to-read bypass.
- Per-register busy scoreboard: decode reserves a destination, writeback releases it, and the block flags read hazards to the issue logic.

Parameters:
- WIDTH, 32, data width of each register and of every data port.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked busy.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- write  input  2  write enables from writeback; bit0 = port 1, bit1 = port 2.
- wr1  input  WIDTH  port 1 write data.
- wr2  input  WIDTH  port 2 write data.
- wa1  input  5  port 1 write address.
- wa2  input  5  port 2 write address.
- ra1  input  5  read port 1 address.
- ra2  input  5  read port 2 address.
- rd1  output  WIDTH  read port 1 data, registered.
- rd2  output  WIDTH  read port 2 data, registered.
- rsv  input  1  reserve request from decode.
- rsv_addr  input  5  destination register to mark busy.
- hz1  output  1  registered: ra1 target busy at the sampling edge.
- hz2  output  1  registered: ra2 target busy at the sampling edge.
- busy  output  32  live scoreboard vector, bit n = register n busy.

Behaviour:
- Reset (rst low, asynchronous): all 32 registers = 0, busy = 0, rd1 = rd2 = 0, hz1 = hz2 = 0. Held while rst is low; release is synchronous to the next clk edge.
- Writes: on the rising edge, write[0] stores wr1 at wa1 and write[1] stores wr2 at wa2.
  - Both bits set with wa1 == wa2: port 2 wins.
  - write = 2'b10 is legal; only port 2 writes.
- Reads: one-cycle latency. ra1/ra2 are sampled at edge N; rd1/rd2 are valid after edge N and hold until the next edge.
  - Read data at edge N is the array content before that edge's writes, unless bypass applies (see Optional Feature).
  - Port 2 has priority in bypass as well.
- ZERO_REG = 1:
  - Any write to address 0 is dropped.
  - Reads of address 0 return 0 even with bypass.
  - Reserves of address 0 are ignored; busy[0] is always 0.
- Scoreboard, per edge and per bit n:
  - Set if rsv && rsv_addr == n.
  - Else clear if (write[0] && wa1 == n) || (write[1] && wa2 == n).
  - Reserve beats release on the same edge, since the new producer owns the register.
  - Releasing a non-busy register is harmless: bit stays 0, data still written.
  - Reserving an already-busy register keeps it busy; there are no counts.
- Hazards:
  - hz1 registered at edge N = busy[ra1] after edge-N release/reserve resolution, and likewise for hz2.
  - So a register released at edge N reports hz = 0 in the same cycle its bypassed data appears.
- No state machine beyond storage and scoreboard; no stall output. The issue logic consumes hz1/hz2.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if a read address matches an active write address at the same edge (address != 0 when ZERO_REG), rd takes the incoming write data (port 2 over port 1) instead of the old array value.
- Undefined: rd always returns pre-edge array content, and a same-edge write becomes visible only on the following read.
- Scoreboard and hz behaviour are identical in both builds.

Test Plan:
- Reset: rst low mid-run after writes -> rd1 = rd2 = 0, busy = 0; after release, reading r5 gives 0.
- Dual write and readback: write = 11, wa1 = 3, wr1 = 0xDEADBEEF, wa2 = 7, wr2 = 0x12345678; next cycle ra1 = 3, ra2 = 7 -> one edge later rd1 = 0xDEADBEEF, rd2 = 0x12345678.
- Port collision: write = 11, wa1 = wa2 = 9, wr1 = 0x1, wr2 = 0x2 -> subsequent read of r9 = 0x2.
- Zero register: write = 01, wa1 = 0, wr1 = 0xFFFFFFFF; ra1 = 0 -> rd1 = 0; rsv = 1, rsv_addr = 0 -> busy[0] = 0.
- Same-edge bypass: r4 = 0xA; write = 01, wa1 = 4, wr1 = 0xB with ra1 = 4 on the same edge -> rd1 = 0xB with REGFILE_BYPASS_EN, rd1 = 0xA without; following read = 0xB in both builds.
- Scoreboard:
  - rsv, rsv_addr = 12 -> busy[12] = 1; ra2 = 12 -> hz2 = 1.
  - write = 01, wa1 = 12 -> busy[12] = 0, and ra2 = 12 at the same edge gives hz2 = 0.
  - Same-edge rsv_addr = 12 with wa1 = 12 -> busy[12] stays 1.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb: 32-entry architectural register file with two write
// ports, two registered read ports and a per-register busy scoreboard.
// Decode reserves a destination, writeback releases it, and hz1/hz2 tell
// the issue logic that a source operand is still owned by a producer.
// Optional build macro: REGFILE_BYPASS_EN (same-edge write-to-read bypass).
module register_file_sb #(
   parameter int WIDTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       write,
   input  logic [WIDTH-1:0] wr1,
   input  logic [WIDTH-1:0] wr2,
   input  logic [4:0]       wa1,
   input  logic [4:0]       wa2,
   input  logic [4:0]       ra1,
   input  logic [4:0]       ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             rsv,
   input  logic [4:0]       rsv_addr,
   output logic             hz1,
   output logic             hz2,
   output logic [31:0]      busy
);

   localparam int NREG = 32;
   localparam bit ZR   = (ZERO_REG != 0);

   logic [WIDTH-1:0] mem_q [NREG];
   logic [WIDTH-1:0] mem_d [NREG];
   logic [WIDTH-1:0] rd1_q, rd1_d;
   logic [WIDTH-1:0] rd2_q, rd2_d;
   logic [31:0]      busy_q, busy_d;
   logic             hz1_q, hz1_d;
   logic             hz2_q, hz2_d;
   logic             we1, we2;

   // Effective write enables: writes to r0 are dropped when it is hardwired.
   always_comb begin
      we1 = write[0] && !(ZR && (wa1 == 5'd0));
      we2 = write[1] && !(ZR && (wa2 == 5'd0));
   end

   // Next array contents; port 2 is applied last so it wins a collision.
   always_comb begin
      for (int n = 0; n < NREG; n++) begin
         mem_d[n] = mem_q[n];
      end
      if (we1) mem_d[wa1] = wr1;
      if (we2) mem_d[wa2] = wr2;
   end

   // Read data selection: pre-edge array content, optionally bypassed.
   always_comb begin
      rd1_d = mem_q[ra1];
      rd2_d = mem_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (we2 && (wa2 == ra1))      rd1_d = wr2;
      else if (we1 && (wa1 == ra1)) rd1_d = wr1;
      if (we2 && (wa2 == ra2))      rd2_d = wr2;
      else if (we1 && (wa1 == ra2)) rd2_d = wr1;
`endif
      if (ZR && (ra1 == 5'd0)) rd1_d = '0;
      if (ZR && (ra2 == 5'd0)) rd2_d = '0;
   end

   // Scoreboard update: release first, then reserve so the new producer wins.
   always_comb begin
      busy_d = busy_q;
      for (int n = 0; n < NREG; n++) begin
         if ((write[0] && (wa1 == n[4:0])) || (write[1] && (wa2 == n[4:0]))) begin
            busy_d[n] = 1'b0;
         end
      end
      if (rsv) busy_d[rsv_addr] = 1'b1;
      if (ZR)  busy_d[0] = 1'b0;
      hz1_d = busy_d[ra1];
      hz2_d = busy_d[ra2];
   end

   // State registers: array, read data, scoreboard and hazard flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int n = 0; n < NREG; n++) begin
            mem_q[n] <= '0;
         end
         rd1_q  <= '0;
         rd2_q  <= '0;
         busy_q <= '0;
         hz1_q  <= 1'b0;
         hz2_q  <= 1'b0;
      end else begin
         for (int n = 0; n < NREG; n++) begin
            mem_q[n] <= mem_d[n];
         end
         rd1_q  <= rd1_d;
         rd2_q  <= rd2_d;
         busy_q <= busy_d;
         hz1_q  <= hz1_d;
         hz2_q  <= hz2_d;
      end
   end

   assign rd1  = rd1_q;
   assign rd2  = rd2_q;
   assign hz1  = hz1_q;
   assign hz2  = hz2_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed vector table, hand-written reset
// sequence, then randomized traffic checked against a reference model.
module tb_register_file_sb;

   localparam int W = 32;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    write = '0;
   logic [W-1:0]  wr1 = '0, wr2 = '0;
   logic [4:0]    wa1 = '0, wa2 = '0, ra1 = '0, ra2 = '0, rsv_addr = '0;
   logic          rsv = 1'b0;
   logic [W-1:0]  rd1, rd2;
   logic          hz1, hz2;
   logic [31:0]   busy;

   always #5 clk = ~clk;

   register_file_sb #(.WIDTH(W), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .write(write), .wr1(wr1), .wr2(wr2),
      .wa1(wa1), .wa2(wa2), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .rsv(rsv), .rsv_addr(rsv_addr), .hz1(hz1), .hz2(hz2), .busy(busy)
   );

   // ---------------- reference model ----------------
   logic [W-1:0] ref_mem [32];
   logic [31:0]  ref_busy;
   logic [W-1:0] exp_rd1, exp_rd2;
   logic         exp_hz1, exp_hz2;
   logic [31:0]  exp_busy;

   int n_checks = 0;
   int n_errors = 0;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      ref_busy = '0;
   endtask

   function automatic logic [W-1:0] model_read(input logic [4:0] ra);
      if (ra == 5'd0) return '0;
      if (BYP && write[1] && wa2 == ra) return wr2;
      if (BYP && write[0] && wa1 == ra) return wr1;
      return ref_mem[ra];
   endfunction

   // Apply the architectural rules to the model for one edge.
   task automatic model_edge();
      exp_rd1 = model_read(ra1);
      exp_rd2 = model_read(ra2);
      if (write[0] && wa1 != 5'd0) ref_mem[wa1] = wr1;
      if (write[1] && wa2 != 5'd0) ref_mem[wa2] = wr2;
      if (write[0]) ref_busy[wa1] = 1'b0;
      if (write[1]) ref_busy[wa2] = 1'b0;
      if (rsv && rsv_addr != 5'd0) ref_busy[rsv_addr] = 1'b1;
      exp_busy = ref_busy;
      exp_hz1  = ref_busy[ra1];
      exp_hz2  = ref_busy[ra2];
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // Drive at the falling edge, advance one rising edge, sample 1 time unit later.
   task automatic step(input logic [1:0] w, input logic [4:0] a1, input logic [W-1:0] d1,
                       input logic [4:0] a2, input logic [W-1:0] d2,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic rs, input logic [4:0] rsa);
      @(negedge clk);
      write = w; wa1 = a1; wr1 = d1; wa2 = a2; wr2 = d2;
      ra1 = r1; ra2 = r2; rsv = rs; rsv_addr = rsa;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [1:0]   w;
      logic [4:0]   a1;
      logic [W-1:0] d1;
      logic [4:0]   a2;
      logic [W-1:0] d2;
      logic [4:0]   r1;
      logic [4:0]   r2;
      logic         rs;
      logic [4:0]   rsa;
      logic [W-1:0] e_rd1;
      logic [W-1:0] e_rd2;
      logic         e_hz1;
      logic         e_hz2;
      logic [31:0]  e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] w, input logic [4:0] a1, input logic [W-1:0] d1,
                      input logic [4:0] a2, input logic [W-1:0] d2,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic rs, input logic [4:0] rsa,
                      input logic [W-1:0] e1, input logic [W-1:0] e2,
                      input logic h1, input logic h2, input logic [31:0] eb);
      vec_t v;
      v.w = w; v.a1 = a1; v.d1 = d1; v.a2 = a2; v.d2 = d2; v.r1 = r1; v.r2 = r2;
      v.rs = rs; v.rsa = rsa; v.e_rd1 = e1; v.e_rd2 = e2; v.e_hz1 = h1; v.e_hz2 = h2;
      v.e_busy = eb;
      vecs.push_back(v);
   endtask

   function automatic logic [W-1:0] sel(input logic [W-1:0] with_byp, input logic [W-1:0] without);
      return BYP ? with_byp : without;
   endfunction

   initial begin
      //   w      a1  d1            a2  d2            r1  r2  rs  rsa  rd1 rd2 hz1 hz2 busy
      add(2'b11, 3, 32'hDEADBEEF, 7, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(2'b00, 0, 0,            0, 0,            3, 7, 0, 0, 32'hDEADBEEF, 32'h12345678, 0, 0, 0);
      add(2'b11, 9, 32'h1,        9, 32'h2,        1, 2, 0, 0, 0, 0, 0, 0, 0);
      add(2'b00, 0, 0,            0, 0,            9, 9, 0, 0, 32'h2, 32'h2, 0, 0, 0);
      add(2'b01, 0, 32'hFFFFFFFF, 0, 0,            0, 3, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0);
      add(2'b00, 0, 0,            0, 0,            0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(2'b01, 4, 32'hA,        0, 0,            3, 7, 0, 0, 32'hDEADBEEF, 32'h12345678, 0, 0, 0);
      add(2'b01, 4, 32'hB,        0, 0,            4, 4, 0, 0, sel(32'hB, 32'hA), sel(32'hB, 32'hA), 0, 0, 0);
      add(2'b00, 0, 0,            0, 0,            4, 9, 0, 0, 32'hB, 32'h2, 0, 0, 0);
      add(2'b00, 0, 0,            0, 0,            0, 12, 1, 12, 0, 0, 0, 1, 32'h0000_1000);
      add(2'b01, 12, 32'h55,      0, 0,            12, 12, 0, 0, sel(32'h55, 0), sel(32'h55, 0), 0, 0, 0);
      add(2'b01, 12, 32'h66,      0, 0,            12, 3, 1, 12, sel(32'h66, 32'h55), 32'hDEADBEEF, 1, 0, 32'h0000_1000);
      add(2'b10, 0, 0,            12, 32'h77,      12, 12, 0, 0, sel(32'h77, 32'h66), sel(32'h77, 32'h66), 0, 0, 0);
      add(2'b00, 0, 0,            0, 0,            20, 12, 1, 20, 0, 32'h77, 1, 0, 32'h0010_0000);
   end

   // ---------------- test sequence ----------------
   initial begin
      model_reset();
      // Reset state while held low.
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd1", rd1, '0);
      check("reset_rd2", rd2, '0);
      check("reset_hz", {30'd0, hz1, hz2}, '0);
      check("reset_busy", busy, '0);
      @(negedge clk);
      rst = 1'b1;

      // Directed table.
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].w, vecs[i].a1, vecs[i].d1, vecs[i].a2, vecs[i].d2,
              vecs[i].r1, vecs[i].r2, vecs[i].rs, vecs[i].rsa);
         check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e_rd1);
         check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e_rd2);
         check($sformatf("vec%0d_hz1", i), {31'd0, hz1}, {31'd0, vecs[i].e_hz1});
         check($sformatf("vec%0d_hz2", i), {31'd0, hz2}, {31'd0, vecs[i].e_hz2});
         check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      end

      // Mid-run asynchronous reset: outputs clear without a clock edge.
      @(negedge clk);
      write = 2'b00; rsv = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_rd1", rd1, '0);
      check("async_rst_rd2", rd2, '0);
      check("async_rst_busy", busy, '0);
      check("async_rst_hz", {30'd0, hz1, hz2}, '0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      step(2'b00, 0, 0, 0, 0, 5, 3, 0, 0);
      check("post_rst_r5", rd1, '0);
      check("post_rst_r3", rd2, '0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(2'($urandom_range(0, 3)),
              5'($urandom_range(0, 15)), $urandom(),
              5'($urandom_range(0, 15)), $urandom(),
              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)));
         check("rand_rd1", rd1, exp_rd1);
         check("rand_rd2", rd2, exp_rd2);
         check("rand_hz1", {31'd0, hz1}, {31'd0, exp_hz1});
         check("rand_hz2", {31'd0, hz2}, {31'd0, exp_hz2});
         check("rand_busy", busy, exp_busy);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
